// File: rtl/mac_cmd_arbiter.sv
// mac_cmd_arbiter: round-robin arbiter that funnels requester commands
// to one accelerator port, with a tile lock and response routing.
module mac_cmd_arbiter #(
  parameter int NREQ  = 2,
  parameter int RID_W = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_instr,
  input  logic [NREQ*32-1:0]   req_rs1,
  input  logic [NREQ*32-1:0]   req_rs2,
  input  logic [NREQ*5-1:0]    req_rd,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [4:0]           rsp_rd,
  output logic [31:0]          rsp_data,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [31:0]          instr,
  output logic [31:0]          rs1_val,
  output logic [31:0]          rs2_val,
  output logic [4:0]           rd_addr,
  input  logic                 rd_we,
  input  logic [4:0]           rd_waddr,
  input  logic [31:0]          rd_wdata,
  input  logic                 accel_busy,
  input  logic                 accel_done,
  output logic                 locked,
  output logic [RID_W-1:0]     lock_owner,
  output logic                 err_unexp_rsp
);

  localparam int CW = RID_W + 1;
  localparam logic [2:0] F_START = 3'b010;
  localparam logic [2:0] F_CRD   = 3'b011;
  localparam logic [2:0] F_STAT  = 3'b100;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t           state;
  logic [RID_W-1:0] rr_ptr;
  logic [RID_W-1:0] cur_id;
  logic [NREQ-1:0]  elig;
  logic             found;
  logic [RID_W-1:0] gnt;
  logic [RID_W-1:0] nxt_ptr;
  logic [CW-1:0]    idx;
  logic             hs;
  logic             start_acc;
  logic             need_rsp;

  function automatic logic is_cls(input logic [31:0] x,
                                  input logic [2:0]  c);
    return x[6:0] == 7'h33 && x[31:25] == 7'h01 && x[14:12] == c;
  endfunction

  // A STAT may bypass the lock; everything else waits for the owner.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++)
      elig[i] = req_valid[i] &&
                (!locked || lock_owner == RID_W'(i) ||
                 is_cls(req_instr[32*i +: 32], F_STAT));
  end

  // Round-robin search for the first eligible requester from rr_ptr.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + CW'(k);
      if (idx >= CW'(NREQ))
        idx = idx - CW'(NREQ);
      if (!found && elig[idx[RID_W-1:0]]) begin
        found = 1'b1;
        gnt   = idx[RID_W-1:0];
      end
    end
  end

  // Grant is combinational and only offered while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && found)
      req_ready[gnt] = 1'b1;
  end

  assign hs        = |(req_valid & req_ready);
  assign nxt_ptr   = (gnt == RID_W'(NREQ - 1)) ? '0 : gnt + RID_W'(1);
  assign start_acc = state == ISSUE && instr_ready &&
                     is_cls(instr, F_START);
  assign need_rsp  = is_cls(instr, F_CRD) || is_cls(instr, F_STAT);

  // Command FSM, lock tracking, response routing and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      cur_id        <= '0;
      locked        <= 1'b0;
      lock_owner    <= '0;
      err_unexp_rsp <= 1'b0;
      instr_valid   <= 1'b0;
      instr         <= '0;
      rs1_val       <= '0;
      rs2_val       <= '0;
      rd_addr       <= '0;
      rsp_valid     <= '0;
      rsp_rd        <= '0;
      rsp_data      <= '0;
    end else begin
      rsp_valid <= '0;
      if (rd_we && state != WAIT_RSP)
        err_unexp_rsp <= 1'b1;
      if (start_acc) begin
        locked     <= 1'b1;
        lock_owner <= cur_id;
      end else if (locked && accel_done && !accel_busy) begin
        locked <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (hs) begin
            instr       <= req_instr[32*gnt +: 32];
            rs1_val     <= req_rs1[32*gnt +: 32];
            rs2_val     <= req_rs2[32*gnt +: 32];
            rd_addr     <= req_rd[5*gnt +: 5];
            cur_id      <= gnt;
            rr_ptr      <= nxt_ptr;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= need_rsp ? WAIT_RSP : IDLE;
          end
        end
        WAIT_RSP: begin
          if (rd_we) begin
            rsp_valid[cur_id] <= 1'b1;
            rsp_rd            <= rd_waddr;
            rsp_data          <= rd_wdata;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_cmd_arbiter.sv
// tb_mac_cmd_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model.
module tb_mac_cmd_arbiter;

  localparam int NREQ  = 2;
  localparam int RID_W = $clog2(NREQ);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_instr = '0;
  logic [NREQ*32-1:0]   req_rs1 = '0;
  logic [NREQ*32-1:0]   req_rs2 = '0;
  logic [NREQ*5-1:0]    req_rd = '0;
  logic [NREQ-1:0]      rsp_valid;
  logic [4:0]           rsp_rd;
  logic [31:0]          rsp_data;
  logic                 instr_valid;
  logic                 instr_ready = 1'b0;
  logic [31:0]          instr;
  logic [31:0]          rs1_val;
  logic [31:0]          rs2_val;
  logic [4:0]           rd_addr;
  logic                 rd_we = 1'b0;
  logic [4:0]           rd_waddr = '0;
  logic [31:0]          rd_wdata = '0;
  logic                 accel_busy = 1'b0;
  logic                 accel_done = 1'b0;
  logic                 locked;
  logic [RID_W-1:0]     lock_owner;
  logic                 err_unexp_rsp;

  always #5 clk = ~clk;

  mac_cmd_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_instr(req_instr), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_rd(rsp_rd),
    .rsp_data(rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rd_addr(rd_addr),
    .rd_we(rd_we), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
    .accel_busy(accel_busy), .accel_done(accel_done),
    .locked(locked), .lock_owner(lock_owner),
    .err_unexp_rsp(err_unexp_rsp)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t",
                  name, got, exp, $time);
  endtask

  // Transaction-level model: one command in flight at most.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    int          id;
  } cmd_t;

  bit              m_busy;
  bit              m_sent;
  bit              m_lk;
  bit              m_err;
  int              m_rr;
  int              m_own;
  cmd_t            m_cur;
  logic [NREQ-1:0] m_rspv;
  logic [4:0]      m_rsprd;
  logic [31:0]     m_rspdata;

  function automatic int cls(input logic [31:0] x);
    if (x[6:0] != 7'h33 || x[31:25] != 7'h01) return -1;
    return int'(x[14:12]);
  endfunction

  function automatic logic [31:0] mk(input logic [2:0] f);
    return {7'h01, 10'd0, f, 5'd0, 7'h33};
  endfunction

  function automatic int mgrant();
    if (!rst_n || m_busy) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_rr + k) % NREQ;
      if (req_valid[i] && (!m_lk || i == m_own ||
          cls(req_instr[32*i +: 32]) == 4))
        return i;
    end
    return -1;
  endfunction

  task automatic mreset();
    m_busy = 0; m_sent = 0; m_lk = 0; m_err = 0;
    m_rr = 0; m_own = 0;
    m_cur = '{instr: '0, rs1: '0, rs2: '0, rd: '0, id: 0};
    m_rspv = '0; m_rsprd = '0; m_rspdata = '0;
  endtask

  task automatic mupdate();
    int  g;
    bit  started;
    g = mgrant();
    m_rspv = '0;
    started = m_busy && !m_sent && instr_ready &&
              cls(m_cur.instr) == 2;
    if (!m_busy) begin
      if (rd_we) m_err = 1;
      if (g >= 0) begin
        m_cur.instr = req_instr[32*g +: 32];
        m_cur.rs1   = req_rs1[32*g +: 32];
        m_cur.rs2   = req_rs2[32*g +: 32];
        m_cur.rd    = req_rd[5*g +: 5];
        m_cur.id    = g;
        m_busy = 1; m_sent = 0;
        m_rr = (g + 1) % NREQ;
      end
    end else if (!m_sent) begin
      if (rd_we) m_err = 1;
      if (instr_ready) begin
        if (cls(m_cur.instr) == 3 || cls(m_cur.instr) == 4) m_sent = 1;
        else m_busy = 0;
      end
    end else if (rd_we) begin
      m_rspv[m_cur.id] = 1'b1;
      m_rsprd = rd_waddr;
      m_rspdata = rd_wdata;
      m_busy = 0;
    end
    if (started) begin
      m_lk = 1; m_own = m_cur.id;
    end else if (m_lk && accel_done && !accel_busy) begin
      m_lk = 0;
    end
  endtask

  task automatic check_all();
    int g;
    logic [NREQ-1:0] er;
    g = mgrant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("instr_valid", instr_valid, m_busy && !m_sent);
    chk("instr", instr, m_cur.instr);
    chk("rs1_val", rs1_val, m_cur.rs1);
    chk("rs2_val", rs2_val, m_cur.rs2);
    chk("rd_addr", rd_addr, m_cur.rd);
    chk("locked", locked, m_lk);
    chk("lock_owner", lock_owner, m_own);
    chk("err_unexp_rsp", err_unexp_rsp, m_err);
    chk("rsp_valid", rsp_valid, m_rspv);
    chk("rsp_rd", rsp_rd, m_rsprd);
    chk("rsp_data", rsp_data, m_rspdata);
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (!rst_n) mreset();
    else mupdate();
    #1;
  endtask

  task automatic clr_inputs();
    req_valid = '0; req_instr = '0; req_rs1 = '0;
    req_rs2 = '0; req_rd = '0;
    instr_ready = 1'b1; rd_we = 1'b0; rd_waddr = '0; rd_wdata = '0;
    accel_busy = 1'b0; accel_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mreset();
    clr_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [31:0] x,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d);
    req_instr[32*i +: 32] = x;
    req_rs1[32*i +: 32] = a;
    req_rs2[32*i +: 32] = b;
    req_rd[5*i +: 5] = d;
  endtask

  function automatic logic [31:0] rand_instr();
    case ($urandom_range(0, 7))
      0, 1, 2, 3, 4: return mk(3'($urandom_range(0, 4)));
      5: return mk(3'($urandom_range(5, 7)));
      6: return {$urandom_range(0, 33554431), 7'h13};
      default: return $urandom;
    endcase
  endfunction

  logic [NREQ-1:0] gq[$];
  logic [NREQ-1:0] exp_seq[4];

  initial begin
    mreset();
    clr_inputs();
    #1;
    // Reset values.
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_rsp_data", rsp_data, 0);
    do_reset();

    // Single WWR forwarded unchanged, no response.
    set_req(0, mk(3'b000), 32'h5, 32'h3F80_0000, 5'd2);
    req_valid = 2'b01;
    #1 chk("t1_ready", req_ready, 2'b01);
    step();
    req_valid = '0;
    chk("t1_ivalid", instr_valid, 1);
    chk("t1_instr", instr, 32'h0200_0033);
    chk("t1_rs1", rs1_val, 32'h5);
    chk("t1_rs2", rs2_val, 32'h3F80_0000);
    step();
    chk("t1_ivalid_low", instr_valid, 0);
    chk("t1_no_rsp", rsp_valid, 0);
    req_valid = 2'b01;
    #1 chk("t1_back_idle", req_ready, 2'b01);
    req_valid = '0;

    // Continuous WWR from both requesters alternates grants.
    do_reset();
    set_req(0, mk(3'b000), 32'h10, 32'h11, 5'd1);
    set_req(1, mk(3'b000), 32'h20, 32'h21, 5'd2);
    req_valid = 2'b11;
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    gq.delete();
    for (int n = 0; n < 20 && gq.size() < 4; n++) begin
      #1;
      if (req_ready != 0) gq.push_back(req_ready);
      step();
    end
    chk("t2_count", gq.size(), 4);
    for (int j = 0; j < 4; j++) chk("t2_grant", gq[j], exp_seq[j]);
    req_valid = '0;

    // Lock held by R0: STAT passes, WWR stalls until release.
    do_reset();
    set_req(0, mk(3'b010), 32'd16, 32'd0, 5'd0);
    req_valid = 2'b01;
    step();
    req_valid = '0;
    step();
    chk("t3_locked", locked, 1);
    chk("t3_owner", lock_owner, 0);
    set_req(1, mk(3'b000), 32'h1, 32'h2, 5'd4);
    req_valid = 2'b10;
    #1 chk("t3_wwr_stall", req_ready, 2'b00);
    set_req(1, mk(3'b100), 32'h3, 32'h4, 5'd5);
    #1 chk("t3_stat_grant", req_ready, 2'b10);
    step();
    set_req(1, mk(3'b000), 32'h1, 32'h2, 5'd4);
    step();
    rd_we = 1'b1; rd_waddr = 5'd5; rd_wdata = 32'h1234;
    step();
    rd_we = 1'b0;
    chk("t3_stat_rsp", rsp_valid, 2'b10);
    chk("t3_wwr_still", req_ready, 2'b00);
    accel_done = 1'b1; accel_busy = 1'b1;
    step();
    step();
    chk("t3_busy_hold", locked, 1);
    accel_busy = 1'b0;
    step();
    accel_done = 1'b0;
    chk("t3_released", locked, 0);
    chk("t3_owner_kept", lock_owner, 0);
    #1 chk("t3_wwr_grant", req_ready, 2'b10);
    step();
    req_valid = '0;
    step();

    // CRD from R1 with a late response.
    do_reset();
    set_req(1, mk(3'b011), 32'h7, 32'h8, 5'd7);
    req_valid = 2'b10;
    step();
    req_valid = '0;
    for (int n = 0; n < 4; n++) step();
    rd_we = 1'b1; rd_waddr = 5'd7; rd_wdata = 32'hDEAD_BEEF;
    step();
    rd_we = 1'b0;
    chk("t4_rsp_valid", rsp_valid, 2'b10);
    chk("t4_rsp_rd", rsp_rd, 5'd7);
    chk("t4_rsp_data", rsp_data, 32'hDEAD_BEEF);
    step();
    chk("t4_pulse_end", rsp_valid, 2'b00);
    chk("t4_data_hold", rsp_data, 32'hDEAD_BEEF);

    // Spurious write-back while idle sets the sticky error.
    rd_we = 1'b1;
    step();
    rd_we = 1'b0;
    chk("t5_err", err_unexp_rsp, 1);
    step();
    step();
    chk("t5_err_sticky", err_unexp_rsp, 1);
    do_reset();
    chk("t5_err_clr", err_unexp_rsp, 0);

    // Reset while waiting for a response abandons it.
    set_req(0, mk(3'b010), 32'h1, 32'h0, 5'd0);
    req_valid = 2'b01;
    step();
    set_req(0, mk(3'b100), 32'h2, 32'h0, 5'd9);
    step();
    step();
    req_valid = '0;
    step();
    chk("t6_locked_pre", locked, 1);
    rst_n = 1'b0;
    mreset();
    #1;
    chk("t6_ivalid", instr_valid, 0);
    chk("t6_rsp", rsp_valid, 0);
    chk("t6_locked", locked, 0);
    req_valid = 2'b01;
    #1 chk("t6_ready_rst", req_ready, 2'b00);
    step();
    rst_n = 1'b1;
    step();
    req_valid = '0;
    step();
    step();
    rd_we = 1'b1; rd_waddr = 5'd9; rd_wdata = 32'hCAFE_F00D;
    step();
    rd_we = 1'b0;
    chk("t6_stat_rsp", rsp_valid, 2'b01);
    chk("t6_stat_data", rsp_data, 32'hCAFE_F00D);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = $urandom_range(0, 99) < 60;
        set_req(i, rand_instr(), $urandom, $urandom,
                5'($urandom_range(0, 31)));
      end
      instr_ready = $urandom_range(0, 99) < 70;
      rd_we = (m_busy && m_sent && $urandom_range(0, 99) < 30) ||
              $urandom_range(0, 299) == 0;
      rd_waddr = 5'($urandom_range(0, 31));
      rd_wdata = $urandom;
      accel_done = $urandom_range(0, 99) < 20;
      accel_busy = $urandom_range(0, 99) < 50;
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
